// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types and sizing constants for the result-broadcast path.
package cdb_arbiter_pkg;

    localparam int unsigned PREG_W         = 7;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned ROB_W          = 6;
    localparam int unsigned NUM_CDB_PORTS  = 2;
    localparam int unsigned CDB_ARB_QDEPTH = 2;

    // One broadcast record; fields other than valid/preg/data ride along untouched.
    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] preg;
        logic [DATA_W-1:0] data;
        logic [ROB_W-1:0]  rob_idx;
        logic              exc;
    } cdb_t;

endpackage

// File: rtl/cdb_res_queue.sv
// Per-FU result FIFO: push/pop in the same cycle, synchronous flush, exposes
// occupancy and the head entry. Caller never pushes when full or pops when empty.
module cdb_res_queue
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned QDEPTH = CDB_ARB_QDEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  cdb_t                         push_data,
    input  logic                         pop,
    output logic [$clog2(QDEPTH+1)-1:0]  count,
    output cdb_t                         head
);

    localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    cdb_t          mem_q [QDEPTH];
    cdb_t          mem_d [QDEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state for storage, pointers and occupancy; flush wins over push/pop.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = cnt_q;
    assign head  = mem_q[rd_q];

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: per-FU result queues, rotating round-robin grant of up to
// N_OUT queue heads per cycle, registered broadcast array.
// Optional build macro CDB_ARB_PERF_CNT_EN adds broadcast/stall counters.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = 7,
    parameter int unsigned N_OUT  = NUM_CDB_PORTS,
    parameter int unsigned QDEPTH = CDB_ARB_QDEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  cdb_t              fu_res   [NUM_FU],
    output logic [NUM_FU-1:0] fu_ready,
    output cdb_t              cdb      [N_OUT]
`ifdef CDB_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_bcast_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int unsigned PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int unsigned CW = $clog2(QDEPTH + 1);

    logic [CW-1:0]     q_count [NUM_FU];
    cdb_t              q_head  [NUM_FU];
    logic [NUM_FU-1:0] q_push;
    logic [NUM_FU-1:0] q_pop;
    logic [NUM_FU-1:0] q_nonempty;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    cdb_t              cdb_q [N_OUT];
    cdb_t              cdb_d [N_OUT];

    for (genvar g = 0; g < NUM_FU; g++) begin : g_queue
        cdb_res_queue #(.QDEPTH(QDEPTH)) u_queue (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .push      (q_push[g]),
            .push_data (fu_res[g]),
            .pop       (q_pop[g]),
            .count     (q_count[g]),
            .head      (q_head[g])
        );
    end

    // Credit from registered occupancy only; preg==0 completes the handshake but is not stored.
    always_comb begin
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            fu_ready[i]   = (q_count[i] < CW'(QDEPTH)) && !rst && !flush;
            q_push[i]     = fu_res[i].valid && fu_ready[i] && (fu_res[i].preg != '0);
            q_nonempty[i] = (q_count[i] != '0);
        end
    end

    // Round-robin scan from rr_ptr: the k-th non-empty head in scan order fills slot k.
    always_comb begin
        int unsigned rr;
        int unsigned n;
        int unsigned last;
        int unsigned pos;
        rr       = 32'(rr_ptr_q);
        n        = 0;
        last     = 0;
        q_pop    = '0;
        rr_ptr_d = rr_ptr_q;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            cdb_d[k] = '0;
        end
        for (int unsigned j = 0; j < NUM_FU; j++) begin
            for (int unsigned i = 0; i < NUM_FU; i++) begin
                pos = (i >= rr) ? (i - rr) : (i + NUM_FU - rr);
                if (pos == j && q_nonempty[i] && n < N_OUT) begin
                    for (int unsigned k = 0; k < N_OUT; k++) begin
                        if (k == n) begin
                            cdb_d[k]       = q_head[i];
                            cdb_d[k].valid = 1'b1;
                        end
                    end
                    q_pop[i] = 1'b1;
                    last     = i;
                    n        = n + 1;
                end
            end
        end
        if (n != 0) begin
            rr_ptr_d = (last == NUM_FU - 1) ? '0 : PW'(last + 1);
        end
        if (flush) begin
            q_pop    = '0;
            rr_ptr_d = '0;
            for (int unsigned k = 0; k < N_OUT; k++) begin
                cdb_d[k].valid = 1'b0;
            end
        end
    end

    // Broadcast registers and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            for (int unsigned k = 0; k < N_OUT; k++) begin
                cdb_q[k] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            cdb_q    <= cdb_d;
        end
    end

    assign cdb = cdb_q;

`ifdef CDB_ARB_PERF_CNT_EN
    logic [31:0] bcast_q, bcast_d;
    logic [31:0] stall_q, stall_d;

    // Saturating event counters; flush does not clear them.
    always_comb begin
        int unsigned nvalid;
        logic        stall_any;
        logic [32:0] sum;
        nvalid    = 0;
        stall_any = 1'b0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            nvalid = nvalid + 32'(cdb_d[k].valid);
        end
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            stall_any = stall_any | (fu_res[i].valid & ~fu_ready[i]);
        end
        sum     = {1'b0, bcast_q} + 33'(nvalid);
        bcast_d = sum[32] ? '1 : sum[31:0];
        stall_d = (stall_any && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcast_q <= '0;
            stall_q <= '0;
        end else begin
            bcast_q <= bcast_d;
            stall_q <= stall_d;
        end
    end

    assign perf_bcast_cnt = bcast_q;
    assign perf_stall_cnt = stall_q;
`endif

`ifndef SYNTHESIS
    // Renaming guarantees a nonzero preg is written by at most one port per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned a = 0; a < N_OUT; a++) begin
                for (int unsigned b = a + 1; b < N_OUT; b++) begin
                    assert (!(cdb_q[a].valid && cdb_q[b].valid &&
                              cdb_q[a].preg != '0 && cdb_q[a].preg == cdb_q[b].preg))
                    else $error("cdb_arbiter: preg %0d driven on two cdb ports", cdb_q[a].preg);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter with NUM_FU=4, N_OUT=2, QDEPTH=2.
// Each row: inputs held for one cycle, fu_ready checked before the edge,
// cdb and rr_ptr checked after it.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned NF = 4;
    localparam int unsigned NO = 2;
    localparam int unsigned NV = 30;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    cdb_t          fu_res [NF];
    logic [NF-1:0] fu_ready;
    cdb_t          cdb [NO];
`ifdef CDB_ARB_PERF_CNT_EN
    logic [31:0]   perf_bcast_cnt;
    logic [31:0]   perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    cdb_arbiter #(.NUM_FU(NF), .N_OUT(NO), .QDEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .fu_res   (fu_res),
        .fu_ready (fu_ready),
        .cdb      (cdb)
`ifdef CDB_ARB_PERF_CNT_EN
        ,
        .perf_bcast_cnt (perf_bcast_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    typedef struct {
        logic       r;
        logic       f;
        logic [3:0] vld;
        logic [6:0] p [4];
        logic [3:0] rdy;
        logic [1:0] ev;
        logic [6:0] e0;
        logic [6:0] e1;
        logic [1:0] rr;
    } vec_t;

    vec_t tv [NV];
    int   checks = 0;
    int   errors = 0;
    int   exp_bc = 0;
    int   exp_st = 0;

    // Result record for a given preg; payload is derived so every slot is distinguishable.
    function automatic cdb_t mk(input logic [6:0] p);
        cdb_t c;
        c.valid   = 1'b1;
        c.preg    = p;
        c.data    = (p == 7'd33) ? 32'hDEAD_BEEF :
                    (p == 7'd0)  ? 32'h0000_1234 : (32'hC0DE_0000 | {25'h0, p});
        c.rob_idx = p[5:0] ^ 6'h2A;
        c.exc     = p[0];
        return c;
    endfunction

    function automatic vec_t row(input logic r, input logic f, input logic [3:0] vld,
                                 input logic [6:0] p0, input logic [6:0] p1,
                                 input logic [6:0] p2, input logic [6:0] p3,
                                 input logic [3:0] rdy, input logic [1:0] ev,
                                 input logic [6:0] e0, input logic [6:0] e1,
                                 input logic [1:0] rr);
        vec_t v;
        v.r = r; v.f = f; v.vld = vld;
        v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
        v.rdy = rdy; v.ev = ev; v.e0 = e0; v.e1 = e1; v.rr = rr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int idx);
        cdb_t x0, x1;
        rst   = v.r;
        flush = v.f;
        for (int i = 0; i < NF; i++) begin
            fu_res[i] = v.vld[i] ? mk(v.p[i]) : '0;
        end
        #1;
        chk($sformatf("ready_row%0d", idx), 64'(fu_ready), 64'(v.rdy));
        @(posedge clk);
        @(negedge clk);
        if (v.r) begin
            exp_bc = 0;
            exp_st = 0;
        end else begin
            exp_bc += int'(v.ev[0]) + int'(v.ev[1]);
            if ((v.vld & ~v.rdy) != 4'b0000) exp_st++;
        end
        x0 = v.ev[0] ? mk(v.e0) : '0;
        x1 = v.ev[1] ? mk(v.e1) : '0;
        if (v.f) begin
            chk($sformatf("cdb0_valid_row%0d", idx), 64'(cdb[0].valid), 64'(x0.valid));
            chk($sformatf("cdb1_valid_row%0d", idx), 64'(cdb[1].valid), 64'(x1.valid));
        end else begin
            chk($sformatf("cdb0_row%0d", idx), 64'(cdb[0]), 64'(x0));
            chk($sformatf("cdb1_row%0d", idx), 64'(cdb[1]), 64'(x1));
        end
        chk($sformatf("rr_ptr_row%0d", idx), 64'(dut.rr_ptr_q), 64'(v.rr));
    endtask

`ifdef CDB_ARB_PERF_CNT_EN
    task automatic chk_perf(input string tag);
        chk({"bcast_", tag}, 64'(perf_bcast_cnt), 64'(exp_bc));
        chk({"stall_", tag}, 64'(perf_stall_cnt), 64'(exp_st));
    endtask
`endif

    initial begin
        //            r  f  vld      p0  p1  p2  p3  rdy      ev     e0  e1  rr
        tv[0]  = row(0, 0, 4'b0100,  0,  0, 33,  0, 4'b1111, 2'b00,  0,  0, 2'd0);
        tv[1]  = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b01, 33,  0, 2'd3);
        tv[2]  = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0, 2'd3);
        tv[3]  = row(0, 0, 4'b1000,  0,  0,  0, 20, 4'b1111, 2'b00,  0,  0, 2'd3);
        tv[4]  = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b01, 20,  0, 2'd0);
        tv[5]  = row(0, 0, 4'b1111, 10, 11, 12, 13, 4'b1111, 2'b00,  0,  0, 2'd0);
        tv[6]  = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b11, 10, 11, 2'd2);
        tv[7]  = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b11, 12, 13, 2'd0);
        tv[8]  = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0, 2'd0);
        tv[9]  = row(0, 0, 4'b1101, 30,  0, 50, 60, 4'b1111, 2'b00,  0,  0, 2'd0);
        tv[10] = row(0, 0, 4'b1111, 31, 40, 51, 61, 4'b1111, 2'b11, 30, 50, 2'd3);
        tv[11] = row(0, 0, 4'b1111, 32, 41, 52, 62, 4'b0111, 2'b11, 60, 31, 2'd1);
        tv[12] = row(0, 0, 4'b1111, 33, 42, 53, 63, 4'b1001, 2'b11, 40, 51, 2'd3);
        tv[13] = row(0, 0, 4'b0010,  0, 42,  0,  0, 4'b0110, 2'b11, 61, 32, 2'd1);
        tv[14] = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1101, 2'b11, 41, 52, 2'd3);
        tv[15] = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b11, 63, 33, 2'd1);
        tv[16] = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b01, 42,  0, 2'd2);
        tv[17] = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0, 2'd2);
        tv[18] = row(0, 0, 4'b1000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0, 2'd2);
        tv[19] = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0, 2'd2);
        tv[20] = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0, 2'd2);
        tv[21] = row(0, 0, 4'b0101, 70,  0, 72,  0, 4'b1111, 2'b00,  0,  0, 2'd2);
        tv[22] = row(0, 1, 4'b0010,  0, 71,  0,  0, 4'b0000, 2'b00,  0,  0, 2'd0);
        tv[23] = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0, 2'd0);
        tv[24] = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0, 2'd0);
        tv[25] = row(0, 0, 4'b0001, 80,  0,  0,  0, 4'b1111, 2'b00,  0,  0, 2'd0);
        tv[26] = row(0, 0, 4'b0100,  0,  0, 82,  0, 4'b1111, 2'b01, 80,  0, 2'd1);
        tv[27] = row(1, 0, 4'b0000,  0,  0,  0,  0, 4'b0000, 2'b00,  0,  0, 2'd0);
        tv[28] = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0, 2'd0);
        tv[29] = row(0, 0, 4'b0000,  0,  0,  0,  0, 4'b1111, 2'b00,  0,  0, 2'd0);

        rst   = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < NF; i++) fu_res[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(fu_ready), 64'(0));
        chk("reset_cdb0", 64'(cdb[0]), 64'(0));
        chk("reset_cdb1", 64'(cdb[1]), 64'(0));
        chk("reset_rr_ptr", 64'(dut.rr_ptr_q), 64'(0));
`ifdef CDB_ARB_PERF_CNT_EN
        chk_perf("reset");
`endif

        for (int i = 0; i < int'(NV); i++) begin
            step(tv[i], i);
`ifdef CDB_ARB_PERF_CNT_EN
            if (i == 26) chk_perf("pre_rst");
`endif
        end
`ifdef CDB_ARB_PERF_CNT_EN
        chk_perf("end");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
